// File: rtl/shift_reg_arbiter_ctrl_if.sv
// ---------------------------------------------------------------------------
// shift_reg_arbiter_ctrl_if
// Bundle between the two requesters, the shared shift register and the
// sequencer/arbiter.
//   req, req_data0/1      requester side: level requests and posted words
//   rx_bit, tx_bit        serial in / serial out (tx_bit valid with tx_valid)
//   reg_dout              shift register Dout feedback
//   reg_din/sel/din_serie shift register controls (SEL=0 load, SEL=1 shift)
//   gnt, done, result     owner, completion pulse and received word
//   busy                  transaction in progress
// slave  : the controller (shift_reg_arbiter_ctrl)
// master : the environment (requesters + register instance)
// ---------------------------------------------------------------------------
interface shift_reg_arbiter_ctrl_if #(
    parameter int NBITS_DATA = 4
);
    logic [1:0]            req;
    logic [NBITS_DATA-1:0] req_data0;
    logic [NBITS_DATA-1:0] req_data1;
    logic                  rx_bit;
    logic [NBITS_DATA-1:0] reg_dout;
    logic [NBITS_DATA-1:0] reg_din;
    logic                  reg_sel;
    logic                  reg_din_serie;
    logic                  tx_bit;
    logic                  tx_valid;
    logic [1:0]            gnt;
    logic [1:0]            done;
    logic [NBITS_DATA-1:0] result;
    logic                  busy;

    modport slave (
        input  req, req_data0, req_data1, rx_bit, reg_dout,
        output reg_din, reg_sel, reg_din_serie, tx_bit, tx_valid,
               gnt, done, result, busy
    );

    modport master (
        output req, req_data0, req_data1, rx_bit, reg_dout,
        input  reg_din, reg_sel, reg_din_serie, tx_bit, tx_valid,
               gnt, done, result, busy
    );
endinterface

// File: rtl/shift_reg_arbiter_ctrl.sv
// ---------------------------------------------------------------------------
// shift_reg_arbiter_ctrl
// Sequencer and round-robin 2-way arbiter for a shared NBITS_DATA
// parallel-load / right-shift register. The winning requester's word is
// loaded, shifted out LSB-first on tx_bit while rx_bit is shifted in at the
// MSB, and the received word is returned with a one-cycle done pulse.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; aborts any transaction without done
//   bus    shift_reg_arbiter_ctrl_if.slave (requests, register controls,
//          serial bits, gnt/done/result/busy)
// ---------------------------------------------------------------------------
module shift_reg_arbiter_ctrl #(
    parameter int NBITS_DATA = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    shift_reg_arbiter_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(NBITS_DATA + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBITS_DATA - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            gnt_q, gnt_d;
    logic [NBITS_DATA-1:0] hold_q, hold_d;
    logic [NBITS_DATA-1:0] result_q, result_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  last_owner_q, last_owner_d;

    logic                  win1;
    logic [NBITS_DATA-1:0] win_data;
    logic [NBITS_DATA-1:0] reg_din;
    logic                  reg_sel;
    logic                  tx_valid;
    logic [1:0]            done;

    // Arbitration: a lone request wins; on a tie the requester that did not
    // own the previous transaction wins (last_owner resets to 1 so that
    // requester 0 takes the first tie).
    always_comb begin
        win1 = 1'b0;
        case (bus.req)
            2'b10:   win1 = 1'b1;
            2'b11:   win1 = ~last_owner_q;
            default: win1 = 1'b0;
        endcase
        win_data = win1 ? bus.req_data1 : bus.req_data0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            gnt_q        <= 2'b00;
            hold_q       <= '0;
            result_q     <= '0;
            cnt_q        <= '0;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            hold_q       <= hold_d;
            result_q     <= result_d;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        hold_d       = hold_q;
        result_d     = result_q;
        cnt_d        = cnt_q;
        last_owner_d = last_owner_q;
        reg_din      = hold_q;
        reg_sel      = 1'b0;
        tx_valid     = 1'b0;
        done         = 2'b00;

        case (state_q)
            S_IDLE: begin
                // Register is reloaded with hold_q every idle cycle, so it
                // keeps presenting the last granted word.
                if (bus.req != 2'b00) begin
                    hold_d       = win_data;
                    gnt_d        = win1 ? 2'b10 : 2'b01;
                    last_owner_d = win1;
                    state_d      = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                reg_sel  = 1'b1;
                tx_valid = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Reload the register with its own output so it holds the
                // received word while it is reported.
                reg_din  = bus.reg_dout;
                done     = gnt_q;
                result_d = bus.reg_dout;
                gnt_d    = 2'b00;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.reg_din       = reg_din;
    assign bus.reg_sel       = reg_sel;
    assign bus.reg_din_serie = bus.rx_bit;
    assign bus.tx_bit        = bus.reg_dout[0];
    assign bus.tx_valid      = tx_valid;
    assign bus.gnt           = gnt_q;
    assign bus.done          = done;
    assign bus.result        = (state_q == S_DONE) ? bus.reg_dout : result_q;
    assign bus.busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_shift_reg_arbiter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_reg_arbiter_ctrl
// Bench for shift_reg_arbiter_ctrl with a behavioural model of the shared
// shift register. Each transaction's expectation (owner, transmitted word,
// rx word to feed, expected result) is queued by the test task that starts
// it; a negedge monitor drives rx_bit from the queue head, captures tx_bit
// and checks the entry when done pulses.
// ---------------------------------------------------------------------------
module tb_shift_reg_arbiter_ctrl;
    localparam int NB = 4;

    logic clk;
    logic reset;

    shift_reg_arbiter_ctrl_if #(.NBITS_DATA(NB)) bus ();

    shift_reg_arbiter_ctrl #(.NBITS_DATA(NB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared register: SEL=0 parallel load, SEL=1 right shift, serial-in at MSB.
    logic [NB-1:0] sr_q = '0;
    always @(posedge clk) begin
        if (bus.reg_sel) sr_q <= {bus.reg_din_serie, sr_q[NB-1:1]};
        else             sr_q <= bus.reg_din;
    end
    assign bus.reg_dout = sr_q;

    typedef struct packed {
        logic [1:0]    gnt;
        logic [NB-1:0] tx;
        logic [NB-1:0] rx;
        logic [NB-1:0] res;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    int            sh_idx = 0;
    logic [NB-1:0] tx_cap = '0;

    // Monitor / scoreboard consumer
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            sh_idx     = 0;
            bus.rx_bit = 1'b0;
        end else begin
            if (bus.tx_valid) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL shift_without_txn: tx_valid=1 but no transaction expected");
                end else if (sh_idx < NB) begin
                    bus.rx_bit     = sb[0].rx[sh_idx];
                    tx_cap[sh_idx] = bus.tx_bit;
                end
                sh_idx++;
            end else begin
                bus.rx_bit = 1'b0;
            end
            if (bus.done != 2'b00) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done: done=%b with empty scoreboard", bus.done);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (bus.done !== e.gnt || bus.gnt !== e.gnt) begin
                        failures++;
                        $display("FAIL sb_done_owner: done=%b gnt=%b expected %b", bus.done, bus.gnt, e.gnt);
                    end
                    checks++;
                    if (tx_cap !== e.tx || sh_idx != NB) begin
                        failures++;
                        $display("FAIL sb_tx_word: tx=%b shifts=%0d expected %b shifts=%0d", tx_cap, sh_idx, e.tx, NB);
                    end
                    checks++;
                    if (bus.result !== e.res) begin
                        failures++;
                        $display("FAIL sb_result: result=%b expected %b", bus.result, e.res);
                    end
                end
                sh_idx = 0;
                tx_cap = '0;
            end
        end
    end

    task automatic test_reset();
        reset         = 1'b1;
        bus.req       = 2'b00;
        bus.req_data0 = '0;
        bus.req_data1 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.gnt !== 2'b00 || bus.done !== 2'b00) begin
            failures++;
            $display("FAIL reset_ctrl: busy=%b gnt=%b done=%b expected 0/00/00", bus.busy, bus.gnt, bus.done);
        end
        checks++;
        if (bus.result !== '0 || bus.reg_din !== '0) begin
            failures++;
            $display("FAIL reset_data: result=%b reg_din=%b expected 0/0", bus.result, bus.reg_din);
        end
        checks++;
        if (bus.reg_sel !== 1'b0 || bus.tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_regif: reg_sel=%b tx_valid=%b expected 0/0", bus.reg_sel, bus.tx_valid);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_shift();
        int n;
        sb.push_back('{2'b01, 4'b0110, 4'b0000, 4'b0000});
        bus.req_data0 = 4'b0110;
        bus.req       = 2'b01;
        n = 0;
        while (bus.gnt == 2'b00 && n < 20) begin @(negedge clk); n++; end
        bus.req = 2'b00;
        @(negedge clk);          // SHIFT 0
        @(negedge clk);          // SHIFT 1
        @(posedge clk);          // two shifts done, now in SHIFT 2
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.gnt !== 2'b00 || bus.done !== 2'b00 || bus.tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_shift: busy=%b gnt=%b done=%b tx_valid=%b expected all 0",
                     bus.busy, bus.gnt, bus.done, bus.tx_valid);
        end
        @(negedge clk);
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_req0();
        int n;
        int cyc;
        sb.push_back('{2'b01, 4'b1011, 4'b1001, 4'b1001});
        bus.req_data0 = 4'b1011;
        bus.req       = 2'b01;
        n = 0;
        while (bus.gnt == 2'b00 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (bus.gnt !== 2'b01) begin
            failures++;
            $display("FAIL single_gnt: gnt=%b expected 01", bus.gnt);
        end
        bus.req = 2'b00;
        // LOAD is busy cycle 1; done must land in busy cycle NB+2.
        cyc = 1;
        while (bus.done == 2'b00 && cyc < 20) begin @(negedge clk); cyc++; end
        checks++;
        if (cyc != NB + 2) begin
            failures++;
            $display("FAIL single_latency: done in cycle %0d expected %0d", cyc, NB + 2);
        end
        @(negedge clk);
        checks++;
        if (bus.result !== 4'b1001 || bus.done !== 2'b00 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL single_hold: result=%b done=%b busy=%b expected 1001/00/0",
                     bus.result, bus.done, bus.busy);
        end
    endtask

    task automatic test_tie_round_robin();
        logic [1:0] exp_g [3];
        int n;
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        bus.req_data0 = 4'hA;
        bus.req_data1 = 4'h5;
        sb.push_back('{2'b01, 4'hA, 4'b0011, 4'b0011});
        sb.push_back('{2'b10, 4'h5, 4'b1100, 4'b1100});
        sb.push_back('{2'b01, 4'hA, 4'b0101, 4'b0101});
        bus.req = 2'b11;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (bus.gnt == 2'b00 && n < 20) begin @(negedge clk); n++; end
            checks++;
            if (bus.gnt !== exp_g[k]) begin
                failures++;
                $display("FAIL tie_gnt[%0d]: gnt=%b expected %b", k, bus.gnt, exp_g[k]);
            end
            n = 0;
            while (bus.done == 2'b00 && n < 20) begin @(negedge clk); n++; end
            checks++;
            if (bus.done !== exp_g[k]) begin
                failures++;
                $display("FAIL tie_done[%0d]: done=%b expected %b", k, bus.done, exp_g[k]);
            end
            if (k == 2) bus.req = 2'b00;
            @(negedge clk);
        end
    endtask

    task automatic test_req1_only();
        int n;
        int busy_cnt;
        sb.push_back('{2'b10, 4'hF, 4'h0, 4'h0});
        bus.req_data1 = 4'hF;
        bus.req       = 2'b10;
        n = 0;
        while (bus.gnt == 2'b00 && n < 20) begin @(negedge clk); n++; end
        bus.req = 2'b00;
        busy_cnt = 0;
        while (bus.busy && busy_cnt < 20) begin busy_cnt++; @(negedge clk); end
        checks++;
        if (busy_cnt != NB + 2) begin
            failures++;
            $display("FAIL req1_busy_len: busy cycles=%0d expected %0d", busy_cnt, NB + 2);
        end
        checks++;
        if (bus.result !== 4'h0) begin
            failures++;
            $display("FAIL req1_result_hold: result=%b expected 0000", bus.result);
        end
    endtask

    task automatic test_late_req();
        int  n;
        bit  gnt_moved;
        sb.push_back('{2'b10, 4'h9, 4'b1010, 4'b1010});
        sb.push_back('{2'b01, 4'h6, 4'b0111, 4'b0111});
        bus.req_data0 = 4'h6;
        bus.req_data1 = 4'h9;
        bus.req       = 2'b10;
        n = 0;
        while (bus.gnt == 2'b00 && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        // Requester 0 arrives mid-SHIFT, requester 1 drops.
        bus.req   = 2'b01;
        gnt_moved = 1'b0;
        n = 0;
        while (bus.done == 2'b00 && n < 20) begin
            if (bus.gnt !== 2'b10) gnt_moved = 1'b1;
            @(negedge clk); n++;
        end
        checks++;
        if (gnt_moved || bus.done !== 2'b10) begin
            failures++;
            $display("FAIL late_first_owner: moved=%0d done=%b expected moved=0 done=10", gnt_moved, bus.done);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.gnt !== 2'b00) begin
            failures++;
            $display("FAIL late_idle_gap: busy=%b gnt=%b expected 0/00", bus.busy, bus.gnt);
        end
        n = 0;
        while (bus.gnt == 2'b00 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (bus.gnt !== 2'b01) begin
            failures++;
            $display("FAIL late_second_gnt: gnt=%b expected 01", bus.gnt);
        end
        bus.req = 2'b00;
        repeat (12) @(negedge clk);
        checks++;
        if (sb.size() != 0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL late_drain: pending=%0d busy=%b expected 0/0", sb.size(), bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        int         rise [3];
        int         txv  [3];
        int         nr;
        logic [1:0] prev_gnt;
        logic       prev_txv;
        bit         gap_bad;
        for (int i = 0; i < 3; i++) begin rise[i] = 0; txv[i] = 0; end
        nr = 0; prev_gnt = 2'b00; prev_txv = 1'b0; gap_bad = 1'b0;
        bus.req_data0 = 4'hC;
        sb.push_back('{2'b01, 4'hC, 4'b1110, 4'b1110});
        sb.push_back('{2'b01, 4'hC, 4'b0001, 4'b0001});
        sb.push_back('{2'b01, 4'hC, 4'b1000, 4'b1000});
        bus.req = 2'b01;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (prev_gnt == 2'b00 && bus.gnt != 2'b00 && nr < 3) begin
                rise[nr] = c;
                nr++;
                if (bus.tx_valid || prev_txv) gap_bad = 1'b1;
                if (nr == 3) bus.req = 2'b00;
            end
            if (bus.tx_valid && nr > 0) txv[nr-1]++;
            prev_gnt = bus.gnt;
            prev_txv = bus.tx_valid;
        end
        checks++;
        if (nr != 3 || rise[1] - rise[0] != NB + 3 || rise[2] - rise[1] != NB + 3) begin
            failures++;
            $display("FAIL b2b_spacing: grants=%0d gaps=%0d,%0d expected 3 grants gaps %0d",
                     nr, rise[1] - rise[0], rise[2] - rise[1], NB + 3);
        end
        checks++;
        if (gap_bad || txv[0] != NB || txv[1] != NB || txv[2] != NB) begin
            failures++;
            $display("FAIL b2b_tx_valid: gap_high=%0d shifts=%0d,%0d,%0d expected 0 and %0d each",
                     gap_bad, txv[0], txv[1], txv[2], NB);
        end
        checks++;
        if (sb.size() != 0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: pending=%0d busy=%b expected 0/0", sb.size(), bus.busy);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_shift();
        test_single_req0();
        test_tie_round_robin();
        test_req1_only();
        test_late_req();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
